// File: rtl/axis_vip_pkg.sv
// Shared AXI-Stream constants and the stored beat layout used by the frame FIFO.
package axis_vip_pkg;

    localparam int AXIS_DATA_W     = 8;
    localparam int AXIS_FIFO_DEPTH = 16;

    typedef struct packed {
        logic                   last;
        logic [AXIS_DATA_W-1:0] data;
    } axis_beat_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// Simple dual-port storage for the frame FIFO: synchronous write, asynchronous read.
module axis_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage write port; contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_frame_fifo.sv
// First-word-fall-through AXI-Stream FIFO with optional line-length checker,
// enabled by defining AXIS_FRAME_FIFO_LAST_CHECK_EN.
module axis_frame_fifo
    import axis_vip_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W,
    parameter int DEPTH  = AXIS_FIFO_DEPTH,
    parameter int LINE_W = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_last,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_last
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          s_ready_q;
    logic          push_s, pop_s;
    logic [DATA_W:0] rd_beat_s;

    assign push_s  = s_valid && s_ready_q;
    assign pop_s   = m_valid && m_ready;
    assign m_valid = (level_q != {LW{1'b0}});
    assign s_ready = s_ready_q;
    assign level   = level_q;
    assign m_data  = rd_beat_s[DATA_W-1:0];
    assign m_last  = rd_beat_s[DATA_W];

    axis_fifo_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (push_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({s_last, s_data}),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_beat_s)
    );

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1'b1);
            2'b01:   level_d = level_q - LW'(1'b1);
            default: level_d = level_q;
        endcase
    end

    // s_ready is registered from next occupancy so it is low throughout reset
    // and never depends combinationally on m_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            level_q   <= {LW{1'b0}};
            s_ready_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            s_ready_q <= (level_d != FULL_LVL);
        end
    end

`ifdef AXIS_FRAME_FIFO_LAST_CHECK_EN
    localparam int CW = $clog2(LINE_W) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(LINE_W - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(LINE_W);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Beat-in-line counter and sticky length-error detection on pushes.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (push_s) begin
            if (s_last) begin
                cnt_d = {CW{1'b0}};
            end else if (cnt_q == MAX_CNT) begin
                cnt_d = MAX_CNT;
            end else begin
                cnt_d = cnt_q + CW'(1'b1);
            end
            if ((s_last && (cnt_q != LAST_CNT)) || (!s_last && (cnt_q == LAST_CNT))) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else begin
            cnt_d = cnt_q;
            err_d = err_q;
        end
    end

    // Checker state; only reset clears the error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_last = err_q;
`else
    // Constant 0 for every legal LINE_W; no checker state exists in this build.
    assign err_last = (LINE_W < 1) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Self-checking bench for axis_frame_fifo (DATA_W=8, DEPTH=4, LINE_W=8): vector table plus scoreboard.
module tb_axis_frame_fifo;

    localparam int DEPTH   = 4;
    localparam int LINE_W  = 8;
    localparam int CYC_MAX = 20000;
`ifdef AXIS_FRAME_FIFO_LAST_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       s_last;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic [2:0] level;
    logic       err_last;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic       err_exp = 1'b0;
    logic [8:0] sb[$];

    typedef struct {
        logic       rst;
        logic       sv;
        logic [7:0] d;
        logic       mr;
        logic [2:0] lvl;
        logic       mv;
        logic       sr;
        logic [7:0] md;
        logic       chk_md;
    } vec_t;

    vec_t tbl[14];

    axis_frame_fifo #(.DATA_W(8), .DEPTH(DEPTH), .LINE_W(LINE_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_last   (s_last),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .level    (level),
        .err_last (err_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle against the queue model: check state, drive, update model, advance.
    task automatic step(input logic sv, input logic [7:0] d, input logic l, input logic mr,
                        output logic pushed);
        logic [8:0] exp_b;
        chk("level", 32'(level), sb.size());
        chk("s_ready", 32'(s_ready), 32'(sb.size() != DEPTH));
        chk("m_valid", 32'(m_valid), 32'(sb.size() != 0));
        chk("err_last", 32'(err_last), 32'(err_exp));
        s_valid = sv;
        s_data  = d;
        s_last  = l;
        m_ready = mr;
        pushed  = sv && (sb.size() != DEPTH);
        if (mr && sb.size() != 0) begin
            exp_b = sb.pop_front();
            chk("beat", 32'({m_last, m_data}), 32'(exp_b));
        end
        if (pushed) begin
            sb.push_back({l, d});
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_err_last", 32'(err_last), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        err_exp = 1'b0;
    endtask

    task automatic drain();
        logic p;
        while (sb.size() != 0 && cyc < CYC_MAX) begin
            step(1'b0, 8'h00, 1'b0, 1'b1, p);
        end
        chk("drained", sb.size(), 32'd0);
    endtask

    initial begin
        logic       p;
        logic [7:0] d8;
        int         sent;

        //              rst   sv    d      mr    lvl   mv    sr    md     chk_md
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 1'b1, 8'h11, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h01, 1'b0, 3'd1, 1'b1, 1'b1, 8'h01, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 8'h02, 1'b0, 3'd2, 1'b1, 1'b1, 8'h01, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 8'h03, 1'b0, 3'd3, 1'b1, 1'b1, 8'h01, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 8'h04, 1'b0, 3'd4, 1'b1, 1'b0, 8'h01, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 8'h55, 1'b1, 3'd3, 1'b1, 1'b1, 8'h02, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 1'b1, 1'b1, 8'h02, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'hA5, 1'b0, 3'd1, 1'b1, 1'b1, 8'hA5, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 8'h00, 1'b0};

        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        m_ready = 1'b0;

        for (int i = 0; i < 14; i++) begin
            reset   = tbl[i].rst;
            s_valid = tbl[i].sv;
            s_data  = tbl[i].d;
            s_last  = 1'b0;
            m_ready = tbl[i].mr;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
            chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].sr));
            chk($sformatf("v%0d_err_last", i), 32'(err_last), 32'd0);
            if (tbl[i].chk_md) begin
                chk($sformatf("v%0d_m_beat", i), 32'({m_last, m_data}), 32'({1'b0, tbl[i].md}));
            end
        end

        // Random 50% valid/ready over 1000 beats in well-formed 8-beat lines.
        do_reset();
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < CYC_MAX) begin
            d8 = 8'($urandom);
            step(1'($urandom_range(0, 1)) && (sent < 1000), d8, (sent % LINE_W) == LINE_W - 1,
                 1'($urandom_range(0, 1)), p);
            if (p) sent++;
        end
        chk("random_sent", sent, 32'd1000);
        drain();
        chk("random_err_last", 32'(err_last), 32'd0);

        // Short line: s_last on the 6th beat, then 20 correct lines.
        do_reset();
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'hC0 + 8'(i), i == 5, 1'b1, p);
        end
        chk("bad_line_err_next", 32'(err_last), 32'(ERR_EN));
        err_exp = ERR_EN;
        for (int ln = 0; ln < 20; ln++) begin
            for (int j = 0; j < LINE_W; j++) begin
                step(1'b1, 8'(ln * 16 + j), j == LINE_W - 1, 1'b1, p);
            end
        end
        drain();
        chk("bad_line_err_sticky", 32'(err_last), 32'(ERR_EN));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
